// File: rtl/shift_rows_stream_if.sv
// Byte-stream bus for the ShiftRows engine: input byte handshake with a
// per-block direction bit, output byte handshake with an end-of-block marker.
`timescale 1ns/1ps
interface shift_rows_stream_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_inv;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    // Producer/consumer side: feeds input bytes, applies output backpressure.
    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // Engine side.
    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/shift_rows_stream.sv
// Byte-serial ShiftRows / InvShiftRows engine. Two ping-pong banks of 4*NB
// bytes: one fills column-major from the input while the other is read out
// through a row-shift address permutation, so blocks stream at byte rate.
`timescale 1ns/1ps
module shift_rows_stream #(
    parameter int NB = 4
) (
    input  logic                clk,
    input  logic                rst,
    shift_rows_stream_if.slave  bus
);

    localparam int NBYTES = 4 * NB;
    localparam int AW     = $clog2(NBYTES);
    localparam int CW     = $clog2(NB);
    localparam logic [AW-1:0] LAST_IDX = AW'(NBYTES - 1);
    localparam logic [CW:0]   NB_W     = NB[CW:0];

    if ((NB != 4) && (NB != 6) && (NB != 8)) begin : g_bad_nb
        $error("shift_rows_stream: NB must be 4, 6 or 8");
    end

    // Row shift offsets; the 256-bit block width uses a wider shift on rows 2 and 3.
    function automatic logic [CW-1:0] row_shift(input logic [1:0] row);
        logic [CW-1:0] s;
        case (row)
            2'd0:    s = CW'(0);
            2'd1:    s = CW'(1);
            2'd2:    s = (NB == 8) ? CW'(3) : CW'(2);
            2'd3:    s = (NB == 8) ? CW'(4) : CW'(3);
            default: s = {CW{1'b0}};
        endcase
        return s;
    endfunction

    // Bank address of the byte that lands at output position k.
    function automatic logic [AW-1:0] src_index(input logic [AW-1:0] k, input logic inv);
        logic [1:0]    row;
        logic [CW:0]   col;
        logic [CW:0]   sh;
        logic [CW:0]   sum;
        row = k[1:0];
        col = {1'b0, k[AW-1:2]};
        sh  = {1'b0, row_shift(row)};
        // Inverse adds NB first so the subtraction never underflows.
        sum = inv ? (col + NB_W - sh) : (col + sh);
        sum = (sum >= NB_W) ? (sum - NB_W) : sum;
        return {sum[CW-1:0], row};
    endfunction

    logic [7:0]    bank_q [2][NBYTES];
    logic [1:0]    full_q, full_d;
    logic [1:0]    inv_q,  inv_d;
    logic          wsel_q, wsel_d;
    logic          rsel_q, rsel_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0] rcnt_q, rcnt_d;

    logic          wr_fire_s;
    logic          rd_fire_s;
    logic [AW-1:0] rd_addr_s;

    // Handshakes and read address come straight from registered state only.
    always_comb begin
        wr_fire_s = bus.in_valid && !full_q[wsel_q];
        rd_fire_s = full_q[rsel_q] && bus.out_ready;
        rd_addr_s = src_index(rcnt_q, inv_q[rsel_q]);
    end

    assign bus.in_ready  = !full_q[wsel_q];
    assign bus.out_valid = full_q[rsel_q];
    assign bus.out_data  = bank_q[rsel_q][rd_addr_s];
    assign bus.out_last  = full_q[rsel_q] && (rcnt_q == LAST_IDX);

    // Next-state for write/read pointers, counters and per-bank flags.
    always_comb begin
        full_d = full_q;
        inv_d  = inv_q;
        wsel_d = wsel_q;
        rsel_d = rsel_q;
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        if (wr_fire_s) begin
            inv_d[wsel_q] = (wcnt_q == {AW{1'b0}}) ? bus.in_inv : inv_q[wsel_q];
            if (wcnt_q == LAST_IDX) begin
                full_d[wsel_q] = 1'b1;
                wcnt_d         = {AW{1'b0}};
                wsel_d         = ~wsel_q;
            end else begin
                wcnt_d = wcnt_q + AW'(1);
            end
        end else begin
            wcnt_d = wcnt_q;
        end
        // A draining bank is never the bank being filled, so both updates to full_d can coexist.
        if (rd_fire_s) begin
            if (rcnt_q == LAST_IDX) begin
                full_d[rsel_q] = 1'b0;
                rcnt_d         = {AW{1'b0}};
                rsel_d         = ~rsel_q;
            end else begin
                rcnt_d = rcnt_q + AW'(1);
            end
        end else begin
            rcnt_d = rcnt_q;
        end
    end

    // Control state register; reset discards any partial or pending block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 2'b00;
            inv_q  <= 2'b00;
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
            wcnt_q <= {AW{1'b0}};
            rcnt_q <= {AW{1'b0}};
        end else begin
            full_q <= full_d;
            inv_q  <= inv_d;
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
        end
    end

    // Byte storage; contents are don't-care until their bank is marked full, so no reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            bank_q[wsel_q][wcnt_q] <= bus.in_data;
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Bench for shift_rows_stream: a row/column reference model drives a
// scoreboard checked every cycle, plus directed vectors with literal results.
`timescale 1ns/1ps
module tb_shift_rows_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_rows_stream_if bus ();
    shift_rows_stream_if bus8 ();

    shift_rows_stream #(.NB(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    shift_rows_stream #(.NB(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int stall_cnt = 0;
    int in_acc = 0;
    int snap = -1;
    int snap_cyc = -1;
    int release_cyc = 0;
    int ready_mode = 0;

    logic [7:0] part_q[$];
    logic       part_inv;
    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    logic       cap_last[$];
    int         cap_cyc[$];
    logic [7:0] cap8[$];
    logic       cap8_last[$];
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    localparam logic [127:0] V_PLAIN = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] V_SHIFT = 128'h0055AAFF4499EE3388DD2277CC1166BB;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: out[r][c] = in[r][(c +/- s_r) mod nb], straight from the row/column rule.
    function automatic logic [7:0] model_byte(input logic [7:0] blk[$], input int nb,
                                              input logic inv, input int k);
        int r, c, s, src;
        r = k % 4;
        c = k / 4;
        s = (nb == 8 && r >= 2) ? r + 1 : r;
        src = inv ? (c - s + nb) % nb : (c + s) % nb;
        return blk[src * 4 + r];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and per-cycle compare for the NB=4 engine.
    always @(negedge clk) begin
        int pend;
        if (rst) begin
            part_q.delete();
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            pend = (exp_q.size() + 15) / 16;
            check("in_ready", 32'(bus.in_ready), 32'(pend < 2));
            check("out_valid", 32'(bus.out_valid), 32'(pend > 0));
            if (bus.out_valid && exp_q.size() > 0) begin
                check("out_data", 32'(bus.out_data), 32'(exp_q[0]));
                check("out_last", 32'(bus.out_last), 32'(exp_q.size() % 16 == 1));
            end
            if (stall_prev) begin
                check("stall_data", 32'(bus.out_data), 32'(prev_data));
                check("stall_last", 32'(bus.out_last), 32'(prev_last));
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                cap_q.push_back(bus.out_data);
                cap_last.push_back(bus.out_last);
                cap_cyc.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready) begin
                in_acc++;
                if (part_q.size() == 0) part_inv = bus.in_inv;
                part_q.push_back(bus.in_data);
                if (part_q.size() == 16) begin
                    for (int k = 0; k < 16; k++) exp_q.push_back(model_byte(part_q, 4, part_inv, k));
                    part_q.delete();
                end
            end
            if (cyc == snap_cyc) snap = in_acc;
        end
    end

    // Capture of the NB=8 engine output.
    always @(negedge clk) begin
        if (!rst && bus8.out_valid && bus8.out_ready) begin
            cap8.push_back(bus8.out_data);
            cap8_last.push_back(bus8.out_last);
        end
    end

    // Output backpressure pattern for the NB=4 engine.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc >= release_cyc);
                2:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic inv);
        int n;
        logic hs;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_inv   = inv;
        forever begin
            @(negedge clk);
            hs = bus.in_ready;
            @(posedge clk);
            #1;
            if (hs) break;
            stall_cnt++;
            n++;
            if (n > 300) begin
                check("send_timeout", 32'(n), 32'(0));
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] v, input logic inv);
        for (int k = 0; k < 16; k++) send_byte(v[127 - 8 * k -: 8], inv);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string name, input logic [127:0] v);
        check({name, "_count"}, 32'(cap_q.size()), 32'(16));
        for (int k = 0; k < 16 && k < cap_q.size(); k++) begin
            check(name, 32'(cap_q[k]), 32'(v[127 - 8 * k -: 8]));
            check({name, "_last"}, 32'(cap_last[k]), 32'(k == 15));
        end
    endtask

    initial begin
        logic [7:0] ramp[$];
        int n;
        #2000000;
        n = 0;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ramp[$];
        int n;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_inv = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_data = 8'h00; bus8.in_inv = 1'b0; bus8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'(1));
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_out_last", 32'(bus.out_last), 32'(0));
        check("rst8_in_ready", 32'(bus8.in_ready), 32'(1));
        check("rst8_out_valid", 32'(bus8.out_valid), 32'(0));
        rst = 1'b0;

        // NB=8: ramp forward then ramp inverse.
        for (int k = 0; k < 32; k++) ramp.push_back(8'(k));
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 32; k++) begin
                logic hs;
                bus8.in_valid = 1'b1; bus8.in_data = 8'(k); bus8.in_inv = (b == 1);
                n = 0;
                forever begin
                    @(negedge clk); hs = bus8.in_ready;
                    @(posedge clk); #1;
                    if (hs) break;
                    n++;
                    if (n > 100) begin check("nb8_send_timeout", 32'(n), 32'(0)); break; end
                end
            end
            bus8.in_valid = 1'b0;
        end
        n = 0;
        while (cap8.size() < 64 && n < 200) begin @(posedge clk); #1; n++; end
        check("nb8_count", 32'(cap8.size()), 32'(64));
        if (cap8.size() >= 64) begin
            check("nb8_byte2", 32'(cap8[2]), 32'h0E);
            check("nb8_byte6", 32'(cap8[6]), 32'h12);
            check("nb8_byte3", 32'(cap8[3]), 32'h13);
            for (int k = 0; k < 32; k++) begin
                check("nb8_fwd", 32'(cap8[k]), 32'(model_byte(ramp, 8, 1'b0, k)));
                check("nb8_inv", 32'(cap8[32 + k]), 32'(model_byte(ramp, 8, 1'b1, k)));
                check("nb8_last", 32'(cap8_last[k]), 32'(k == 31));
            end
        end

        // NB=4 directed forward and inverse.
        cap_q.delete(); cap_last.delete(); cap_cyc.delete();
        send_block(V_PLAIN, 1'b0);
        wait_drain();
        check_vec("fwd", V_SHIFT);
        cap_q.delete(); cap_last.delete(); cap_cyc.delete();
        send_block(V_SHIFT, 1'b1);
        wait_drain();
        check_vec("inv", V_PLAIN);

        // Back-to-back, alternating direction, no bubbles.
        ready_mode = 0;
        stall_cnt = 0;
        cap_q.delete(); cap_last.delete(); cap_cyc.delete();
        for (int j = 0; j < 4; j++) send_block(j[0] ? V_SHIFT : V_PLAIN, j[0]);
        check("b2b_in_stalls", 32'(stall_cnt), 32'(0));
        wait_drain();
        check("b2b_count", 32'(cap_q.size()), 32'(64));
        if (cap_cyc.size() == 64) check("b2b_gapless", 32'(cap_cyc[63] - cap_cyc[0]), 32'(63));

        // Backpressure: 40 stalled cycles with 3 blocks offered.
        release_cyc = cyc + 40;
        snap_cyc = release_cyc - 1;
        in_acc = 0;
        ready_mode = 1;
        for (int j = 0; j < 48; j++) send_byte(8'($urandom), 1'($urandom));
        check("bp_buffered", 32'(snap), 32'(32));
        wait_drain();
        ready_mode = 0;

        // Reset during input, then during output byte 5.
        for (int j = 0; j < 7; j++) send_byte(8'($urandom), 1'b0);
        rst = 1'b1;
        #1;
        check("rst_in_mid_ready", 32'(bus.in_ready), 32'(1));
        check("rst_in_mid_valid", 32'(bus.out_valid), 32'(0));
        @(posedge clk); #1; rst = 1'b0;
        cap_q.delete(); cap_last.delete(); cap_cyc.delete();
        send_block(V_PLAIN, 1'b0);
        n = 0;
        while (cap_q.size() < 5 && n < 100) begin @(posedge clk); #1; n++; end
        check("rst_out_reached", 32'(cap_q.size()), 32'(5));
        check("rst_out_pre_valid", 32'(bus.out_valid), 32'(1));
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_out_in_ready", 32'(bus.in_ready), 32'(1));
        check("rst_out_last0", 32'(bus.out_last), 32'(0));
        @(posedge clk); #1; rst = 1'b0;
        cap_q.delete(); cap_last.delete(); cap_cyc.delete();
        send_block(V_SHIFT, 1'b1);
        wait_drain();
        check_vec("post_rst", V_PLAIN);

        // Randomized traffic with random gaps and backpressure.
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_byte(8'($urandom), 1'($urandom));
        end
        ready_mode = 0;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_rows_stream.md
# shift_rows_stream

Byte-serial, parametrised ShiftRows / InvShiftRows engine for the Rijndael datapath. It accepts a state of 4×NB bytes one byte per cycle in column-major order and emits the row-shifted state one byte per cycle. It uses ping-pong state buffers, so back-to-back blocks stream at full byte rate. It replaces the combinational 128-bit shift stage wherever the datapath is byte-serial, and supports the 128/192/256-bit Rijndael block widths and both directions.

## Interface
- NB, default 4: state columns. Legal values are 4, 6, 8; any other value is an elaboration error.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input byte valid
- in_ready  out  1  engine can accept an input byte
- in_data  in  8  input byte; byte k maps to row k%4, column k/4
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled with byte 0 of each block, ignored otherwise
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts the output byte
- out_data  out  8  shifted byte; byte k maps to row k%4, column k/4
- out_last  out  1  high with byte 4·NB−1 of each block

## Operation
- Shift offsets s_r for rows 0..3:
  - NB=4 and NB=6: 0,1,2,3.
  - NB=8: 0,1,3,4.
- Output mapping, with r = k%4 and c = k/4:
  - Forward: out[r][c] = in[r][(c+s_r) mod NB].
  - Inverse: out[r][c] = in[r][(c−s_r+NB) mod NB].
  - Modulo arithmetic is on column indices of width clog2(NB); there is no overflow beyond NB−1.
- Storage: two banks, each 4·NB bytes, plus per-bank full flag and inv flag.
- Write side:
  - Pointer wsel and counter wcnt (0..4·NB−1).
  - in_ready = !full[wsel].
  - On each handshake (in_valid && in_ready), write bank[wsel][wcnt] and increment wcnt.
  - At wcnt==0, latch inv[wsel] = in_inv.
  - At wcnt==4·NB−1: set full[wsel], reset wcnt to 0, toggle wsel.
- Read side:
  - Pointer rsel and counter rcnt.
  - out_valid = full[rsel].
  - out_data = bank[rsel][src(rcnt, inv[rsel])], selected combinationally from registered storage.
  - out_last = out_valid && rcnt==4·NB−1.
  - On each handshake, increment rcnt. On the last byte: clear full[rsel], reset rcnt to 0, toggle rsel.
- Output stability: while out_valid && !out_ready, out_data and out_last hold stable.
- Direction is per block: consecutive blocks may alternate direction.

## Timing
- Reset values, applied asynchronously on rst:
  - in_ready=1, out_valid=0, out_last=0, out_data=bank0[0].
  - full=0, inv=0, wsel=rsel=0, wcnt=rcnt=0.
  - Bank contents are not reset.
- Reset mid-block: all partial input and pending output are discarded. The next accepted byte is byte 0 of a new block.
- Latency: if the last input byte is accepted at edge N, out_valid rises after edge N and byte 0 is presented in cycle N+1.
- Throughput: one byte per cycle sustained. With out_ready held high, block j+1 input overlaps block j output with no bubbles.
- Both banks full: in_ready=0 until a bank drains. If a bank's last byte is read at edge M, full clears at edge M and in_ready rises in the cycle after M.
  - There is no combinational path from out_ready to in_ready.
- Simultaneous events: in the same cycle as one bank drains, the other bank may be written. Because wsel≠rsel whenever both are active, no conflict arises.
- Bank hand-off: full set by the write side and full cleared by the read side never target the same bank on the same edge.
- in_data and in_inv are ignored when in_valid && in_ready is false.

## Test plan
- NB=4 forward: stream 0x00112233445566778899AABBCCDDEEFF as bytes MSB-first → out 0x0055AAFF4499EE3388DD2277CC1166BB, out_last on byte 15, first out_valid the cycle after input byte 15 is accepted.
- NB=4 inverse: stream 0x0055AAFF4499EE3388DD2277CC1166BB with in_inv=1 → out 0x00112233445566778899AABBCCDDEEFF.
- NB=8 forward: input bytes 0x00..0x1F → row 2 outputs columns 3,4,5,6,7,0,1,2, i.e. out byte 2 = 0x0E, out byte 6 = 0x12. Row 3 outputs out byte 3 = 0x13.
- Back-to-back with alternating direction: 4 blocks at NB=4, in_valid and out_ready held high → 64 output bytes with no gap, in_ready never drops, each block uses its own direction.
- Backpressure: out_ready low for 40 cycles while 3 blocks are offered → in_ready falls after 2 blocks are buffered, out_data is stable while stalled, all data arrives intact and in order after release.
- Reset mid-stream: assert rst after 7 input bytes and again during output byte 5 → out_valid drops immediately, in_ready=1, the next full block outputs correctly with no stale bytes.
